// File: rtl/sram_mem_ctrl_pkg.sv
// Shared constants for the memory-stage SRAM controller.
// Word/half-word widths, default data-memory base and FSM state encodings.
// Also provides the wait-counter width helper.
package sram_mem_ctrl_pkg;

    localparam int WORD = 32;
    localparam int HALF = 16;

    localparam logic [WORD-1:0] DEFAULT_BASE_ADDR = 32'd1024;

    // FSM state encodings
    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_LO   = 2'd1;
    localparam logic [1:0] MEM_HI   = 2'd2;
    localparam logic [1:0] MEM_DONE = 2'd3;

    // Wait counter needs at least one bit even when each phase is a single cycle.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sram_mem_ctrl.sv
// Memory-stage responder: each 32-bit load/store becomes two 16-bit SRAM phases (low half, then high half).
// Latency: strobe seen in IDLE at cycle 0, LO = 1..W, HI = W+1..2W, DONE = 2W+1 with read_data valid.
// Backpressure: ready is low from the strobed IDLE cycle through HI; the pipeline must hold its request until DONE.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter logic [WORD-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int              WAIT_CYCLES = 2,
    parameter int              SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [WORD-1:0]    address,
    input  logic [WORD-1:0]    write_data,
    output logic [WORD-1:0]    read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [HALF-1:0]    sram_dq_out,
    input  logic [HALF-1:0]    sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int            CW       = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    logic [1:0]         state_q,     state_d;
    logic [CW-1:0]      wait_cnt_q,  wait_cnt_d;
    logic               is_wr_q,     is_wr_d;
    logic [WORD-1:0]    read_data_q, read_data_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [HALF-1:0]    dq_out_q,    dq_out_d;
    logic               dq_oe_q,     dq_oe_d;
    logic               we_n_q,      we_n_d;

    logic [WORD-1:0]    off;
    logic [SRAM_AW-2:0] word_idx;
    logic               req;
    logic               phase_end;
    logic               unused_addr_bits;

    // Offset wraps modulo 2^32 and is not range-checked; byte-within-word bits are dropped.
    assign off              = address - BASE_ADDR;
    assign word_idx         = off[SRAM_AW:2];
    assign unused_addr_bits = ^{off[WORD-1:SRAM_AW+1], off[1:0]};

    assign req       = mem_read | mem_write;
    assign phase_end = (wait_cnt_q == CNT_LAST);

    // Next-state logic: phase sequencing, SRAM pin setup for the coming cycle and read capture.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;

        case (state_q)
            MEM_IDLE: begin
                if (req) begin
                    // A write wins when both strobes are high.
                    state_d     = MEM_LO;
                    wait_cnt_d  = '0;
                    is_wr_d     = mem_write;
                    sram_addr_d = {word_idx, 1'b0};
                    dq_out_d    = write_data[15:0];
                    dq_oe_d     = mem_write;
                    we_n_d      = ~mem_write;
                end
            end
            MEM_LO: begin
                if (phase_end) begin
                    if (!is_wr_q) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                    state_d     = MEM_HI;
                    wait_cnt_d  = '0;
                    sram_addr_d = {sram_addr_q[SRAM_AW-1:1], 1'b1};
                    dq_out_d    = write_data[31:16];
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            MEM_HI: begin
                if (phase_end) begin
                    if (!is_wr_q) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                    // Release the bus as DONE begins.
                    state_d    = MEM_DONE;
                    wait_cnt_d = '0;
                    dq_oe_d    = 1'b0;
                    we_n_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            MEM_DONE: begin
                // Requests seen here are the one just completed; never re-trigger on them.
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // State and registered SRAM controls; reset drops the access and releases the SRAM at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MEM_IDLE;
            wait_cnt_q  <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    // ready is combinational so the freeze takes effect in the same cycle the strobe appears.
    assign ready = ~((state_q == MEM_LO) || (state_q == MEM_HI) ||
                     ((state_q == MEM_IDLE) && req));

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: vector table, randomized accesses against a word-level
// reference memory, reset abort mid-write and back-to-back accesses on a single-wait-cycle instance.
module tb_sram_mem_ctrl;

    localparam int          AW   = 18;
    localparam int          WA   = 2;
    localparam int          WB   = 1;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          TMO  = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A (W = 2)
    logic          mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0]   address = '0, write_data = '0, read_data;
    logic          ready, sram_dq_oe, sram_we_n;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;

    // Instance B (W = 1)
    logic          mem_read_b = 1'b0, mem_write_b = 1'b0;
    logic [31:0]   address_b = '0, write_data_b = '0, read_data_b;
    logic          ready_b, sram_dq_oe_b, sram_we_n_b;
    logic [AW-1:0] sram_addr_b;
    logic [15:0]   sram_dq_out_b, sram_dq_in_b;

    sram_mem_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(WA), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    sram_mem_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(WB), .SRAM_AW(AW)) dut_b (
        .clk(clk), .rst(rst), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .address(address_b), .write_data(write_data_b), .read_data(read_data_b), .ready(ready_b),
        .sram_addr(sram_addr_b), .sram_dq_out(sram_dq_out_b), .sram_dq_in(sram_dq_in_b),
        .sram_dq_oe(sram_dq_oe_b), .sram_we_n(sram_we_n_b)
    );

    // Asynchronous SRAM models: combinational read, write committed on a clock edge while enabled.
    logic [15:0] mem_a [0:(1<<AW)-1];
    logic [15:0] mem_b [0:(1<<AW)-1];
    assign sram_dq_in   = mem_a[sram_addr];
    assign sram_dq_in_b = mem_b[sram_addr_b];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem_a[sram_addr] <= sram_dq_out;
        if (!sram_we_n_b && sram_dq_oe_b) mem_b[sram_addr_b] <= sram_dq_out_b;
    end

    // Word-level reference memory, keyed by word index
    logic [31:0] ref_mem [int];
    logic [31:0] exp_last;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int word_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) & ((32'd1 << (AW - 1)) - 1));
    endfunction

    function automatic logic [31:0] ref_rd(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    // Drive one access on instance A from IDLE (called #1 after a rising edge) and check every cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input int exp_lo, input logic [31:0] exp_rd, input string tag);
        int n;
        int half;
        int exp_addr;
        mem_read = rd; mem_write = wr; address = a; write_data = wd;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < TMO) begin
            if (n >= 1 && n <= 2 * WA) begin
                half     = (n - 1) / WA;
                exp_addr = (exp_lo + half) & ((1 << AW) - 1);
                chk($sformatf("%s_addr_c%0d", tag, n), 32'(sram_addr), 32'(exp_addr));
                chk($sformatf("%s_oe_c%0d", tag, n), 32'(sram_dq_oe), 32'(wr));
                chk($sformatf("%s_we_n_c%0d", tag, n), 32'(sram_we_n), 32'(!wr));
                if (wr) chk($sformatf("%s_dq_c%0d", tag, n), 32'(sram_dq_out),
                            32'(half ? wd[31:16] : wd[15:0]));
            end
            n++;
            @(negedge clk);
        end
        chk({tag, "_ready_low_cycles"}, n, 2 * WA + 1);
        chk({tag, "_read_data"}, read_data, exp_rd);
        chk({tag, "_done_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_done_oe"}, 32'(sram_dq_oe), 32'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, 32'(ready), 32'd1);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lo_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];
    logic exp_seq [8];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 2,      32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        2,      32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 0,      32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        0,      32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd1030, 32'h0,        2,      32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 32'd1427, 32'hA5A55A5A, 200,    32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b0, 32'd1424, 32'h0,        200,    32'hA5A55A5A};
        vecs[7] = '{1'b1, 1'b0, 32'd1020, 32'h0,        262142, 32'h00000000};

        for (int i = 0; i < (1 << AW); i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_read_data", read_data, 32'h0);
        @(posedge clk); #1;

        // Vector table
        exp_last = 32'h0;
        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].lo_addr, vecs[i].exp_rd, $sformatf("vec%0d", i));
            if (vecs[i].wr) begin
                ref_mem[word_index(vecs[i].addr)] = vecs[i].wdata;
                chk($sformatf("vec%0d_sram_lo", i), 32'(mem_a[vecs[i].lo_addr]), 32'(vecs[i].wdata[15:0]));
                chk($sformatf("vec%0d_sram_hi", i), 32'(mem_a[vecs[i].lo_addr + 1]), 32'(vecs[i].wdata[31:16]));
            end else begin
                exp_last = vecs[i].exp_rd;
            end
        end

        // Reset during the first HI cycle of a write
        mem_write = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_in_hi_addr", 32'(sram_addr), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        mem_write = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_read_data", read_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        // Low half completed before the abort; the high half keeps its old contents.
        ref_mem[0] = {16'h1234, 16'hF00D};
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 0, ref_rd(0), "rd_after_abort");
        exp_last = ref_rd(0);

        // Randomized accesses against the reference memory
        for (int i = 0; i < 30; i++) begin
            int          wi;
            int          kind;
            logic        rd, wr;
            logic [31:0] a, wd, exp;
            wi   = int'($urandom_range(0, 15));
            kind = int'($urandom_range(0, 3));
            a    = BASE + 32'(wi * 4) + 32'($urandom_range(0, 3));
            wd   = $urandom;
            rd   = (kind != 1);
            wr   = (kind == 1) || (kind == 2);
            exp  = (rd && !wr) ? ref_rd(wi) : exp_last;
            do_access(rd, wr, a, wd, wi * 2, exp, $sformatf("rnd%0d", i));
            if (wr) ref_mem[wi] = wd;
            else    exp_last = exp;
        end

        // Back-to-back load then store on the single-wait-cycle instance
        for (int i = 0; i < 8; i++) exp_seq[i] = ((i % (2 * WB + 2)) == 2 * WB + 1);
        mem_b[4] = 16'h3333;
        mem_b[5] = 16'h4444;
        mem_read_b = 1'b1; address_b = 32'd1032;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_%0d", i), 32'(ready_b), 32'(exp_seq[i]));
            if (i == 2 * WB + 1) begin
                chk("b2b_load_data", read_data_b, 32'h44443333);
                mem_read_b = 1'b0; mem_write_b = 1'b1;
                address_b = 32'd1036; write_data_b = 32'h55667788;
            end
            if (i == 7) mem_write_b = 1'b0;
        end
        @(posedge clk); #1;
        chk("b2b_store_lo", 32'(mem_b[6]), 32'h7788);
        chk("b2b_store_hi", 32'(mem_b[7]), 32'h5566);
        chk("b2b_read_data_kept", read_data_b, 32'h44443333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
